sram_fifo_ctrl: RTL and testbench
=================================

Name: sram_fifo_ctrl

Overview:
- FIFO controller that turns the team's single-port synchronous SRAM into a first-word-fall-through queue.
- Sits directly upstream of the SRAM and drives its addr/csen_n/wren_n/data_i pins. Consumes its data_o, which arrives one cycle after a read.
- Exposes valid/ready push and pop interfaces, arbitrates the single SRAM port, and tracks the SRAM's 1-cycle read latency.

Parameters:
- ADDR_WIDTH, 4, SRAM address width; queue storage depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data width; must match the SRAM.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  push request
- in_ready  output  1  push accepted when in_valid && in_ready
- in_data  input  DATA_WIDTH  push data
- out_valid  output  1  out_data holds the head entry
- out_ready  input  1  pop when out_valid && out_ready
- out_data  output  DATA_WIDTH  head entry
- sram_addr  output  ADDR_WIDTH  to SRAM addr
- sram_csen_n  output  1  to SRAM csen_n, active low
- sram_wren_n  output  1  to SRAM wren_n; 0 = write, 1 = read
- sram_wdata  output  DATA_WIDTH  to SRAM data_i
- sram_rdata  input  DATA_WIDTH  from SRAM data_o

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- State registers:
  - wr_ptr, rd_ptr: ADDR_WIDTH bits; wrap naturally DEPTH-1 -> 0.
  - mem_cnt: ADDR_WIDTH+1 bits; entries written but not yet read-issued, range 0..DEPTH.
  - rd_inflight: 1 bit.
  - rr: 1 bit; 1 = write has priority.
  - out_valid, out_data.
- Reset values: all pointers and counters 0, rd_inflight=0, rr=0, out_valid=0, out_data=0. While rst=1: sram_csen_n=1, sram_wren_n=1, in_ready=0.
- full = (mem_cnt == DEPTH). empty_mem = (mem_cnt == 0).
- rd_elig = !empty_mem && !rd_inflight && (!out_valid || out_ready).
- in_ready = !full && (!rd_elig || rr). in_ready does not depend on in_valid.
- Port use per cycle, combinational from state and inputs:
  - Write (in_valid && in_ready): csen_n=0, wren_n=0, addr=wr_ptr, wdata=in_data.
  - Else read (rd_elig): csen_n=0, wren_n=1, addr=rd_ptr.
  - Else idle: csen_n=1, wren_n=1, addr=0, wdata=0.
- rr update: when both write and read wanted the port in a cycle (in_valid && !full && rd_elig), rr toggles. Otherwise rr holds. This prevents starvation of either side.
- Write fire: wr_ptr+1, mem_cnt+1.
- Read issue: rd_ptr+1, mem_cnt-1, rd_inflight=1 next cycle.
- The two mem_cnt updates are mutually exclusive because the port is single.
- Read return: in the cycle after issue, sram_rdata is valid. out_data <= sram_rdata, out_valid <= 1, rd_inflight <= 0.
- Pop without a simultaneous return: out_valid <= 0.
- Latency:
  - Push into an empty queue at cycle N: read issues at N+1, out_valid=1 at N+3.
  - Pop at cycle M with mem_cnt>0 and no push contention: next head valid at M+2.
- Throughput: at most one read per 2 cycles. Writes reach 1 per cycle when no reads are eligible.
- Boundaries:
  - Push while full: not accepted.
  - Pop while !out_valid: ignored.
  - Simultaneous push and pop: resolved by rr.
  - A read never targets an unwritten slot, and a write never targets rd_ptr while a read is pending.
  - Total occupancy is at most DEPTH+1 (SRAM plus output register).
- Reset mid-operation: any in-flight read is discarded, out_valid=0 on the next cycle, and queue contents are lost.

Optional Feature:
- Macro: SRAM_FIFO_LEVEL_EN.
- Defined: adds output port level, width ADDR_WIDTH+1, registered. level = mem_cnt + rd_inflight + out_valid, saturating at DEPTH+1. Reset value 0. Updates on the same edge as the state it reflects.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package sram_fifo_pkg:
  - default widths;
  - port-op encoding constants OP_IDLE, OP_WR, OP_RD, used by the bench for SRAM pin checking.
- One natural sub-module: sram_port_arb. It holds rr and produces the op select from in_valid, full, and rd_elig.
- Pointers, counters, and the output register stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> out_valid=0, in_ready=0, sram_csen_n=1. After release, in_ready=1.
- Single push 0xA5 at cycle N into an empty queue with out_ready=0 -> SRAM write at addr 0 in N, read at addr 0 in N+1, out_valid=1 with out_data=0xA5 at N+3. Data holds until popped.
- Fill: push 0x00..0x10 with out_ready=0 -> 17 pushes accepted (16 in SRAM, 1 in the output register). in_ready=0 afterwards, and an extra push of 0xFF is dropped.
- Drain after fill: out_ready=1 -> pops 0x00..0x10 in order, one every 2 cycles. Pointer wrap 15 -> 0 is exercised.
- Contention: continuous in_valid and out_ready with mem_cnt>0 -> SRAM ops alternate write/read on contended cycles. Neither side stalls more than 1 consecutive contended cycle, and data order is preserved.
- Reset mid-read: assert rst in the cycle after a read issue -> out_valid stays 0 and mem_cnt=0. A fresh push of 0x3C then emerges as the first output.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// Shared definitions for the SRAM-backed FWFT FIFO controller:
// default widths and the SRAM port-operation encoding.
package sram_fifo_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 8;

    typedef logic [1:0] port_op_t;

    localparam port_op_t OP_IDLE = 2'b00;
    localparam port_op_t OP_WR   = 2'b01;
    localparam port_op_t OP_RD   = 2'b10;

endpackage

// File: rtl/sram_port_arb.sv
// Arbiter for the single SRAM port. A push and an eligible read compete for
// the port; the round-robin bit rr (1 = write wins) flips on every contended
// cycle so neither side can be starved.
module sram_port_arb
    import sram_fifo_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     in_valid,
    input  logic     full,
    input  logic     rd_elig,
    output logic     in_ready,
    output port_op_t op
);

    logic rr;
    logic contend;

    // Ready/op selection; reset forces the port idle and refuses pushes.
    always_comb begin
        contend  = in_valid && !full && rd_elig;
        in_ready = !rst && !full && (!rd_elig || rr);
        op       = OP_IDLE;
        if (!rst) begin
            if (in_valid && in_ready) begin
                op = OP_WR;
            end else if (rd_elig) begin
                op = OP_RD;
            end
        end
    end

    // Priority flips only when both sides actually wanted the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (contend) begin
            rr <= ~rr;
        end
    end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// First-word-fall-through FIFO built on a single-port synchronous SRAM with
// a 1-cycle read latency. The head entry is held in an output register; the
// SRAM holds the rest. Optional macro SRAM_FIFO_LEVEL_EN adds a registered
// occupancy port 'level' (SRAM entries + in-flight read + output register).
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_csen_n,
    output logic                  sram_wren_n,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata
`ifdef SRAM_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level
`endif
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic                  rd_inflight;

    logic                  full;
    logic                  empty_mem;
    logic                  rd_elig;
    port_op_t              op;
    logic                  wr_fire;
    logic                  rd_issue;

    logic [ADDR_WIDTH:0]   nxt_mem_cnt;
    logic                  nxt_out_valid;

    // A read is only worth issuing when its data will have somewhere to land
    // on the return cycle: output register empty or being popped now.
    always_comb begin
        full      = (mem_cnt == DEPTH_C);
        empty_mem = (mem_cnt == '0);
        rd_elig   = !empty_mem && !rd_inflight && (!out_valid || out_ready);
        wr_fire   = (op == OP_WR);
        rd_issue  = (op == OP_RD);
    end

    sram_port_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .full     (full),
        .rd_elig  (rd_elig),
        .in_ready (in_ready),
        .op       (op)
    );

    // Drive the SRAM pins from the selected port operation.
    always_comb begin
        sram_csen_n = 1'b1;
        sram_wren_n = 1'b1;
        sram_addr   = '0;
        sram_wdata  = '0;
        case (op)
            OP_WR: begin
                sram_csen_n = 1'b0;
                sram_wren_n = 1'b0;
                sram_addr   = wr_ptr;
                sram_wdata  = in_data;
            end
            OP_RD: begin
                sram_csen_n = 1'b0;
                sram_addr   = rd_ptr;
            end
            default: begin
            end
        endcase
    end

    // Next-state for the counters shared by the state registers and level.
    always_comb begin
        nxt_mem_cnt = mem_cnt;
        if (wr_fire) begin
            nxt_mem_cnt = mem_cnt + 1'b1;
        end else if (rd_issue) begin
            nxt_mem_cnt = mem_cnt - 1'b1;
        end
        nxt_out_valid = out_valid;
        if (rd_inflight) begin
            nxt_out_valid = 1'b1;
        end else if (out_valid && out_ready) begin
            nxt_out_valid = 1'b0;
        end
    end

    // Pointers, count, read tracking and output register; reset drops any
    // in-flight read so stale SRAM data never reaches the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            rd_inflight <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            mem_cnt     <= nxt_mem_cnt;
            rd_inflight <= rd_issue;
            out_valid   <= nxt_out_valid;
            if (rd_inflight) begin
                out_data <= sram_rdata;
            end
        end
    end

`ifdef SRAM_FIFO_LEVEL_EN
    localparam logic [ADDR_WIDTH+1:0] LVL_MAX = (ADDR_WIDTH + 2)'(DEPTH + 1);

    logic [ADDR_WIDTH+1:0] level_sum;

    // Occupancy computed from next-state so it tracks the same edge.
    always_comb begin
        level_sum = {1'b0, nxt_mem_cnt}
                  + (ADDR_WIDTH + 2)'(rd_issue)
                  + (ADDR_WIDTH + 2)'(nxt_out_valid);
    end

    // Registered, saturating occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else if (level_sum > LVL_MAX) begin
            level <= LVL_MAX[ADDR_WIDTH:0];
        end else begin
            level <= level_sum[ADDR_WIDTH:0];
        end
    end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Testbench for sram_fifo_ctrl with a behavioural single-port SRAM model.
module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW-1:0] sram_addr;
    logic          sram_csen_n;
    logic          sram_wren_n;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata;
`ifdef SRAM_FIFO_LEVEL_EN
    logic [AW:0]   level;
`endif

    always #5 clk = ~clk;

    sram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .sram_addr   (sram_addr),
        .sram_csen_n (sram_csen_n),
        .sram_wren_n (sram_wren_n),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
`ifdef SRAM_FIFO_LEVEL_EN
        ,
        .level       (level)
`endif
    );

    // Single-port synchronous SRAM, data_o valid the cycle after a read.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (!sram_csen_n) begin
            if (!sram_wren_n) mem[sram_addr] <= sram_wdata;
            else              sram_rdata <= mem[sram_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic port_op_t pins_op();
        if (sram_csen_n) return OP_IDLE;
        if (sram_wren_n) return OP_RD;
        return OP_WR;
    endfunction

    // Apply inputs mid-cycle, then let combinational outputs settle.
    task automatic drive(input logic r, input logic iv, input logic [DW-1:0] d,
                         input logic ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
    endtask

    task automatic push_one(input logic [DW-1:0] d, input string nm);
        int ok = 0;
        for (int t = 0; t < 20 && ok == 0; t++) begin
            drive(1'b0, 1'b1, d, 1'b0);
            if (in_ready) ok = 1;
        end
        chk(nm, ok, 1);
    endtask

    typedef struct {
        logic          rst;
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
        port_op_t      e_op;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
    } vec_t;

    vec_t tbl [11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int popped;
        int last;
        int nxt;
        int stall;
        int maxstall;
        int pops;
        int lastpop;
        logic [DW-1:0] sb [$];

        //            rst   iv    d      ordy  e_ov  e_od   e_ir  e_op     addr  wd
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, OP_IDLE, 4'd0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0, OP_IDLE, 4'd0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, OP_IDLE, 4'd0, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, OP_IDLE, 4'd0, 8'h00};
        tbl[4]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b1, OP_WR,   4'd0, 8'hA5};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, OP_RD,   4'd0, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, OP_IDLE, 4'd0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, OP_IDLE, 4'd0, 8'h00};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b1, OP_IDLE, 4'd0, 8'h00};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b1, OP_IDLE, 4'd0, 8'h00};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, OP_IDLE, 4'd0, 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        // Reset, then a single push travelling through to the output.
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("r%0d_out_valid", i), int'(out_valid), int'(tbl[i].e_ov));
            chk($sformatf("r%0d_out_data", i), int'(out_data), int'(tbl[i].e_od));
            chk($sformatf("r%0d_in_ready", i), int'(in_ready), int'(tbl[i].e_ir));
            chk($sformatf("r%0d_op", i), int'(pins_op()), int'(tbl[i].e_op));
            chk($sformatf("r%0d_addr", i), int'(sram_addr), int'(tbl[i].e_addr));
            if (tbl[i].e_op == OP_WR)
                chk($sformatf("r%0d_wdata", i), int'(sram_wdata), int'(tbl[i].e_wd));
        end

        // Fill: 16 SRAM entries plus the output register.
        acc = 0;
        for (int t = 0; t < 60 && acc < 17; t++) begin
            drive(1'b0, 1'b1, 8'(acc), 1'b0);
            if (in_ready) acc++;
        end
        chk("fill_accepted", acc, 17);
        for (int t = 0; t < 3; t++) begin
            drive(1'b0, 1'b1, 8'hFF, 1'b0);
            chk("full_in_ready", int'(in_ready), 0);
            chk("full_op", int'(pins_op()), int'(OP_IDLE));
        end
        chk("full_out_valid", int'(out_valid), 1);
        chk("full_head", int'(out_data), 0);
`ifdef SRAM_FIFO_LEVEL_EN
        chk("full_level", int'(level), 17);
`endif

        // Drain: in order, one pop every two cycles, no trace of 0xFF.
        popped = 0;
        last   = 0;
        for (int t = 0; t < 80 && popped < 17; t++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            if (out_valid) begin
                chk($sformatf("drain_data%0d", popped), int'(out_data), popped);
                if (popped > 0) chk($sformatf("drain_gap%0d", popped), cyc - last, 2);
                last = cyc;
                popped++;
            end
        end
        chk("drain_count", popped, 17);
        for (int t = 0; t < 3; t++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("drain_empty_valid", int'(out_valid), 0);
        chk("drain_empty_ready", int'(in_ready), 1);

        // Contention: continuous push and pop.
        nxt = 8'h40; stall = 0; maxstall = 0; pops = 0; lastpop = 0;
        for (int t = 0; t < 40; t++) begin
            drive(1'b0, 1'b1, 8'(nxt), 1'b1);
            if (in_ready) begin
                sb.push_back(8'(nxt));
                nxt++;
                stall = 0;
            end else begin
                stall++;
                if (stall > maxstall) maxstall = stall;
            end
            if (out_valid) begin
                chk("cont_nonempty", int'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("cont_data", int'(out_data), int'(sb.pop_front()));
                if (pops > 0) chk("cont_pop_gap_le3", int'((cyc - lastpop) <= 3), 1);
                lastpop = cyc;
                pops++;
            end
        end
        chk("cont_max_wr_stall", maxstall, 1);
        chk("cont_pops_min", int'(pops >= 8), 1);
        for (int t = 0; t < 80 && sb.size() != 0; t++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1);
            if (out_valid) chk("cont_drain_data", int'(out_data), int'(sb.pop_front()));
        end
        chk("cont_drained", int'(sb.size()), 0);
        for (int t = 0; t < 3; t++) drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("cont_idle_valid", int'(out_valid), 0);

        // Reset in the cycle after a read issue.
        push_one(8'h11, "rm_push11");
        push_one(8'h22, "rm_push22");
        for (int t = 0; t < 5; t++) drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rm_head", int'(out_data), 8'h11);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rm_read_issue", int'(pins_op()), int'(OP_RD));
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        chk("rm_rst_in_ready", int'(in_ready), 0);
        chk("rm_rst_csen", int'(sram_csen_n), 1);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rm_post_valid", int'(out_valid), 0);
        chk("rm_post_op", int'(pins_op()), int'(OP_IDLE));
`ifdef SRAM_FIFO_LEVEL_EN
        chk("rm_post_level", int'(level), 0);
`endif
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rm_post_valid2", int'(out_valid), 0);
        drive(1'b0, 1'b1, 8'h3C, 1'b0);
        chk("rm_3c_write", int'(pins_op()), int'(OP_WR));
        chk("rm_3c_addr", int'(sram_addr), 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rm_3c_read", int'(pins_op()), int'(OP_RD));
        chk("rm_3c_raddr", int'(sram_addr), 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rm_3c_n2_valid", int'(out_valid), 0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rm_3c_valid", int'(out_valid), 1);
        chk("rm_3c_data", int'(out_data), 8'h3C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
